header_extractor_blocking: RTL and testbench

HEADER_EXTRACTOR_BLOCKING -- requirements
Module: header_extractor_blocking

---
 rtl/header_extractor_blocking_pkg.sv | 16 +
 rtl/header_extractor_blocking.sv | 171 +++++++++++++++++
 tb/tb_header_extractor_blocking.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/header_extractor_blocking_pkg.sv
// Shared state encodings and helpers for the header stream blocks.
// Optional drop path is enabled by HEADER_EXTRACT_DROP_EN.
package header_extractor_blocking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MID  = 2'b01,
    LST  = 2'b10,
    DRP  = 2'b11
  } hx_state_t;

  function automatic int unsigned hx_max1(input int unsigned v);
    return (v > 0) ? v : 1;
  endfunction

endpackage

// File: rtl/header_extractor_blocking.sv
// Strips a low-aligned header from the first stream word and re-packs the payload.
// Define HEADER_EXTRACT_DROP_EN to honour the drop input (DRP state).
module header_extractor_blocking
  import header_extractor_blocking_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int HDR_WIDTH  = 64,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_STRB   = HDR_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,

  output logic [HDR_WIDTH-1:0]  m_hdr_tdata,
  output logic [DEST_WIDTH-1:0] m_hdr_tdest,
  output logic                  m_hdr_tvalid,
  input  logic                  m_hdr_tready,
  input  logic                  drop,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [STRB_WIDTH-1:0] m_axis_tkeep,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int REST_W = hx_max1(DATA_WIDTH - HDR_WIDTH);
  localparam int REST_K = hx_max1(STRB_WIDTH - HDR_STRB);

  hx_state_t state, state_nx;

  logic [REST_W-1:0]     rest_data;
  logic [REST_K-1:0]     rest_keep;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [USER_WIDTH-1:0] user_q;

  logic                  strb_left;
  logic [REST_W-1:0]     up_data;
  logic [REST_K-1:0]     up_keep;
  logic [DATA_WIDTH-1:0] mid_data;
  logic [STRB_WIDTH-1:0] mid_keep;
  logic [DATA_WIDTH-1:0] lst_data;
  logic [STRB_WIDTH-1:0] lst_keep;
  logic                  s_hs;

  assign s_hs = s_axis_tvalid && s_axis_tready;

  generate
    if (DATA_WIDTH > HDR_WIDTH) begin : g_split
      assign strb_left = |s_axis_tkeep[STRB_WIDTH-1:HDR_STRB];
      assign up_data   = s_axis_tdata[DATA_WIDTH-1:HDR_WIDTH];
      assign up_keep   = s_axis_tkeep[STRB_WIDTH-1:HDR_STRB];
      assign mid_data  = {s_axis_tdata[HDR_WIDTH-1:0], rest_data};
      assign mid_keep  = {s_axis_tkeep[HDR_STRB-1:0], rest_keep};
      assign lst_data  = {{HDR_WIDTH{1'b0}}, rest_data};
      assign lst_keep  = {{HDR_STRB{1'b0}}, rest_keep};
    end else begin : g_pass
      // Header fills the whole word: payload words pass straight through
      assign strb_left = 1'b0;
      assign up_data   = '0;
      assign up_keep   = '0;
      assign mid_data  = s_axis_tdata;
      assign mid_keep  = s_axis_tkeep;
      assign lst_data  = '0;
      assign lst_keep  = '0;
    end
  endgenerate

`ifdef HEADER_EXTRACT_DROP_EN
  logic drop_eff;
  assign drop_eff = drop;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (s_hs) begin
      rest_data <= up_data;
      rest_keep <= up_keep;
    end
    if (state == IDLE) begin
      dest_q <= s_axis_tdest;
      user_q <= s_axis_tuser;
    end
  end

  assign m_hdr_tdata  = s_axis_tdata[HDR_WIDTH-1:0];
  assign m_hdr_tdest  = s_axis_tdest;
  assign m_axis_tdest = dest_q;
  assign m_axis_tuser = user_q;

  always_comb begin
    state_nx      = state;
    s_axis_tready = 1'b0;
    m_hdr_tvalid  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = mid_data;
    m_axis_tkeep  = mid_keep;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        m_hdr_tvalid  = s_axis_tvalid;
        s_axis_tready = m_hdr_tready;
        if (s_axis_tvalid && m_hdr_tready) begin
`ifdef HEADER_EXTRACT_DROP_EN
          if (drop_eff) begin
            state_nx = s_axis_tlast ? IDLE : DRP;
          end else
`endif
          if (!s_axis_tlast) begin
            state_nx = MID;
          end else if (strb_left) begin
            state_nx = LST;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      MID: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tlast  = s_axis_tlast && !strb_left;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_nx = strb_left ? LST : IDLE;
        end
      end
      LST: begin
        m_axis_tdata  = lst_data;
        m_axis_tkeep  = lst_keep;
        m_axis_tlast  = 1'b1;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          state_nx = IDLE;
        end
      end
`ifdef HEADER_EXTRACT_DROP_EN
      DRP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nx = IDLE;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_header_extractor_blocking.sv
// Scoreboard bench for header_extractor_blocking (128-bit data, 64-bit header).
// Payload expectations come from a byte-stream model of each packet.
module tb_header_extractor_blocking;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic [7:0]   s_axis_tdest;
  logic [7:0]   s_axis_tuser;
  logic         s_axis_tlast;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [63:0]  m_hdr_tdata;
  logic [7:0]   m_hdr_tdest;
  logic         m_hdr_tvalid;
  logic         m_hdr_tready;
  logic         drop;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic [7:0]   m_axis_tdest;
  logic [7:0]   m_axis_tuser;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;

  header_extractor_blocking dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_hdr_tdata(m_hdr_tdata), .m_hdr_tdest(m_hdr_tdest),
    .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
    .drop(drop),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [7:0]   dest;
    logic [7:0]   user;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  dest;
  } hdr_t;

  beat_t exp_axis[$];
  hdr_t  exp_hdr[$];

  int tests = 0;
  int fails = 0;
  int drp_cnt = 0;

  logic         rnd_en = 1'b0;
  logic         rdy_cmd = 1'b1;
  logic [127:0] pw[8];
  logic [15:0]  pk[8];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkw(input int s);
    logic [127:0] w;
    for (int b = 0; b < 16; b++) w[b*8 +: 8] = 8'(s * 16 + b);
    return w;
  endfunction

  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_cmd;
  end

  logic         stall_prev = 1'b0;
  logic [127:0] sv_data;
  logic [15:0]  sv_keep;
  logic         sv_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("axis_hold_valid", 128'(m_axis_tvalid), 128'(1));
        chk("axis_hold_data", m_axis_tdata, sv_data);
        chk("axis_hold_keep", 128'(m_axis_tkeep), 128'(sv_keep));
        chk("axis_hold_last", 128'(m_axis_tlast), 128'(sv_last));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      sv_data = m_axis_tdata;
      sv_keep = m_axis_tkeep;
      sv_last = m_axis_tlast;

      if (s_axis_tvalid && s_axis_tready && !m_hdr_tvalid && !m_axis_tvalid)
        drp_cnt++;

      if (m_hdr_tvalid && m_hdr_tready) begin
        if (exp_hdr.size() == 0) begin
          chk("hdr_unexpected", 128'(1), 128'(0));
        end else begin
          hdr_t h;
          h = exp_hdr.pop_front();
          chk("hdr_data", 128'(m_hdr_tdata), 128'(h.data));
          chk("hdr_dest", 128'(m_hdr_tdest), 128'(h.dest));
        end
      end

      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_axis.size() == 0) begin
          chk("axis_unexpected", 128'(1), 128'(0));
        end else begin
          beat_t e;
          logic [127:0] mask;
          e = exp_axis.pop_front();
          for (int b = 0; b < 16; b++) mask[b*8 +: 8] = {8{e.keep[b]}};
          chk("axis_data", m_axis_tdata & mask, e.data & mask);
          chk("axis_keep", 128'(m_axis_tkeep), 128'(e.keep));
          chk("axis_last", 128'(m_axis_tlast), 128'(e.last));
          chk("axis_dest", 128'(m_axis_tdest), 128'(e.dest));
          chk("axis_user", 128'(m_axis_tuser), 128'(e.user));
        end
      end
    end
  end

  task automatic wait_hs();
    int t = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      t++;
      if (t > 300) begin
        chk("handshake_timeout", 128'(1), 128'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input bit dp, input logic [7:0] d,
                          input logic [7:0] u, input bit hstall);
    byte unsigned bq[$];
    bit fwd;
    hdr_t h;
    h.data = pw[0][63:0];
    h.dest = d;
    exp_hdr.push_back(h);
    fwd = 1'b1;
`ifdef HEADER_EXTRACT_DROP_EN
    if (dp) fwd = 1'b0;
`endif
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 16; b++)
        if (pk[w][b] && !(w == 0 && b < 8)) bq.push_back(pw[w][b*8 +: 8]);
    while (fwd && bq.size() > 0) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int b = 0; b < 16; b++) begin
        if (bq.size() > 0) begin
          e.data[b*8 +: 8] = bq.pop_front();
          e.keep[b] = 1'b1;
        end
      end
      e.last = (bq.size() == 0);
      e.dest = d;
      e.user = u;
      exp_axis.push_back(e);
    end
    for (int w = 0; w < n; w++) begin
      s_axis_tdata  = pw[w];
      s_axis_tkeep  = pk[w];
      s_axis_tdest  = (w == 0) ? d : 8'hEE;
      s_axis_tuser  = (w == 0) ? u : 8'hDD;
      s_axis_tlast  = (w == n - 1);
      s_axis_tvalid = 1'b1;
      drop          = dp;
      if (w == 0 && hstall) begin
        m_hdr_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("hstall_sready", 128'(s_axis_tready), 128'(0));
          chk("hstall_hvalid", 128'(m_hdr_tvalid), 128'(1));
          chk("hstall_hdata", 128'(m_hdr_tdata), 128'(pw[0][63:0]));
        end
        @(posedge clk);
        #1;
        m_hdr_tready = 1'b1;
      end
      wait_hs();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drop          = 1'b0;
  endtask

  initial begin
    int d0;
    int t;
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tdest = '0;
    s_axis_tuser = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_hdr_tready = 1'b0;
    drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset_axis_valid", 128'(m_axis_tvalid), 128'(0));
    chk("reset_hdr_valid", 128'(m_hdr_tvalid), 128'(0));
    @(posedge clk);
    #1;
    s_axis_tdata = mkw(9);
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("reset_hdr_follows", 128'(m_hdr_tvalid), 128'(1));
    chk("reset_sready", 128'(s_axis_tready), 128'(0));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    m_hdr_tready = 1'b1;

    // 3 full words: two packed beats plus an LST tail
    for (int i = 0; i < 3; i++) begin pw[i] = mkw(i + 1); pk[i] = 16'hFFFF; end
    send_pkt(3, 1'b0, 8'h11, 8'hA1, 1'b0);

    // header only, immediately followed by the next packet
    pw[0] = mkw(5); pk[0] = 16'h00FF;
    send_pkt(1, 1'b0, 8'h22, 8'hA2, 1'b0);

    // single word with 4 tail bytes, LST held by backpressure
    rdy_cmd = 1'b0;
    @(posedge clk);
    #1;
    pw[0] = mkw(6); pk[0] = 16'h0FFF;
    send_pkt(1, 1'b0, 8'h33, 8'hA3, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("lst_sready", 128'(s_axis_tready), 128'(0));
      chk("lst_valid", 128'(m_axis_tvalid), 128'(1));
      chk("lst_last", 128'(m_axis_tlast), 128'(1));
    end
    rdy_cmd = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 2 words, last word exactly fills one beat: no LST
    pw[0] = mkw(7); pk[0] = 16'hFFFF;
    pw[1] = mkw(8); pk[1] = 16'h00FF;
    send_pkt(2, 1'b0, 8'h44, 8'hA4, 1'b0);
    @(negedge clk);
    chk("no_lst_after_exact", 128'(m_axis_tvalid), 128'(0));

    // header stall then random downstream backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin pw[i] = mkw(10 + i); pk[i] = 16'hFFFF; end
    pw[4] = mkw(14); pk[4] = 16'h0003;
    send_pkt(5, 1'b0, 8'h55, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin pw[i] = mkw(20 + i); pk[i] = 16'hFFFF; end
    pw[3] = mkw(23); pk[3] = 16'h7FFF;
    send_pkt(4, 1'b0, 8'h56, 8'hA6, 1'b0);
    rnd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // drop a 4-word packet, then a normal packet
    d0 = drp_cnt;
    for (int i = 0; i < 4; i++) begin pw[i] = mkw(30 + i); pk[i] = 16'hFFFF; end
    send_pkt(4, 1'b1, 8'h66, 8'hA7, 1'b0);
`ifdef HEADER_EXTRACT_DROP_EN
    chk("drp_cycles", 128'(drp_cnt - d0), 128'(3));
`else
    chk("no_drp_cycles", 128'(drp_cnt - d0), 128'(0));
`endif
    for (int i = 0; i < 2; i++) begin pw[i] = mkw(40 + i); pk[i] = 16'hFFFF; end
    send_pkt(2, 1'b0, 8'h77, 8'hA8, 1'b0);

    t = 0;
    while ((exp_axis.size() > 0 || exp_hdr.size() > 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("axis_queue_drained", 128'(exp_axis.size()), 128'(0));
    chk("hdr_queue_drained", 128'(exp_hdr.size()), 128'(0));
    chk("final_axis_idle", 128'(m_axis_tvalid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
